dram_cmd_scheduler: RTL and testbench
=====================================

# dram_cmd_scheduler

In-order DRAM command scheduler between the memory request queue and the DIMM command output. It accepts one parsed request at a time, tracks open rows per bank (open-page policy) and emits ACT/PRE/RD/WR commands that honour tRCD, tRP, tRAS, tRTP and write recovery. It pulses completion once the data burst has finished.

## Interface
- BG_WIDTH, 2: bank-group address bits.
- BA_WIDTH, 2: bank address bits; NUM_BANKS = 2^(BG_WIDTH+BA_WIDTH).
- ROW_WIDTH, 15: row address bits.
- COL_WIDTH, 8: column address bits.
- CNT_WIDTH, 8: width of every timing counter.
- T_RCD, 24; T_RP, 24; T_RAS, 52; T_CL, 24; T_CWL, 20; T_BURST, 4; T_WR, 20; T_RTP, 12: timings in clk cycles.
- Elaboration `$fatal` if any T_* < 1, or if T_CL+T_BURST or T_CWL+T_BURST+T_WR exceeds 2^CNT_WIDTH-1.

Ports:
- clk  in  1  scheduler clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request available; fields held stable while req_valid && !req_ready.
- req_ready  out  1  high exactly when state == IDLE.
- req_opcode  in  2  0 data read, 1 data write, 2 instruction fetch (read), 3 treated as read.
- req_bg  in  BG_WIDTH  bank group.
- req_ba  in  BA_WIDTH  bank.
- req_row  in  ROW_WIDTH  row.
- req_col  in  COL_WIDTH  column.
- cmd_valid  out  1  one-cycle command strobe, registered.
- cmd_type  out  3  0 NOP, 1 ACT, 2 PRE, 3 RD, 4 WR.
- cmd_bg  out  BG_WIDTH  command bank group.
- cmd_ba  out  BA_WIDTH  command bank.
- cmd_addr  out  ROW_WIDTH  row for ACT, zero-extended column for RD/WR, 0 for PRE.
- req_done  out  1  one-cycle pulse; the accepted request is complete.

## Operation
- Bank index b = {bg, ba}. Per-bank state: open flag, open_row, and three saturating down-counters: act_cnt, col_cnt, pre_cnt. A counter at 0 permits ACT, RD/WR or PRE respectively. Each counter decrements by 1 per edge until it reaches 0.
- Events on bank b:
  - ACT: col_cnt = T_RCD-1; pre_cnt = T_RAS-1; open = 1; open_row = row.
  - PRE: act_cnt = T_RP-1; open = 0.
  - RD: pre_cnt = max(pre_cnt, T_RTP-1).
  - WR: pre_cnt = max(pre_cnt, T_CWL+T_BURST+T_WR-1).
- FSM states:
  - IDLE: on the edge where req_valid && req_ready, latch the request and go to SCHED.
  - SCHED: each edge, evaluate the latched bank. Exactly one outcome applies.
    - Open and row hit, col_cnt == 0: issue RD/WR; data_cnt = (read ? T_CL : T_CWL)+T_BURST-1; go to DATA.
    - Open and row miss, pre_cnt == 0: issue PRE; stay in SCHED.
    - Closed, act_cnt == 0: issue ACT; stay in SCHED.
    - Otherwise: no command; stay in SCHED.
  - DATA: decrement data_cnt. On the edge where data_cnt == 0, set req_done for one cycle and go to IDLE.
- At most one command per cycle. When no command is issued, cmd_valid = 0 and cmd_type = NOP.
- Counters of all banks run in every state. Banks other than the latched one keep their open/row state indefinitely (no auto-precharge, no refresh).

## Timing
- Reset values: cmd_valid 0, cmd_type 0, cmd_bg/ba/addr 0, req_done 0, req_ready 1. All banks are closed and all counters are 0.
- Command outputs appear in the cycle after the deciding edge. With accept at edge 0 and counters clear, the first command is visible in cycle 1.
- Command spacing on one bank, measured edge to edge:
  - ACT→RD/WR: ≥ T_RCD.
  - ACT→PRE: ≥ T_RAS.
  - PRE→ACT: ≥ T_RP.
  - RD→PRE: ≥ T_RTP.
  - WR→PRE: ≥ T_CWL+T_BURST+T_WR.
  - Each spacing is exact when it is the only constraint.
- RD issued at edge R: req_done is high in the cycle after edge R+T_CL+T_BURST. For WR, substitute T_CWL.
- req_ready is high in the same cycle as req_done, so the earliest next accept is the edge that ends that cycle.
- req_valid while not ready: nothing is latched and there is no side effect.
- Reset mid-operation: the request is aborted and req_done is not pulsed. All banks are closed and counters cleared, matching a DIMM reset.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs 0 immediately, req_ready 1 after release.
- Closed-bank read bg0 ba0 row 0x10 col 0x05, accept at edge 0 -> ACT row 0x10 visible in cycle 1, RD col 0x05 in cycle 25, req_done in cycle 53.
- Row-hit write to the same bank/row, accepted once col_cnt is 0 -> no ACT, WR in the cycle after accept, req_done 24 cycles after WR.
- Row miss: read row 0x20 on bg0 ba0 immediately after the write -> PRE no earlier than 44 edges after WR and 52 after ACT; ACT row 0x20 24 edges after PRE; RD 24 edges after ACT.
- Bank independence: read bg1 ba3 row 0x7 while bg0 ba0 is open on 0x20, then read bg0 ba0 row 0x20 -> the second request issues RD with no ACT/PRE.
- Reset during DATA of a read -> no req_done; the next request to that bank begins with ACT.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// In-order DRAM command scheduler. It takes one request at a time and keeps
// the open row of every bank open (open-page policy). It issues ACT, PRE, RD
// and WR while honouring per-bank tRCD, tRP, tRAS, tRTP and write-recovery
// windows. req_done pulses once the data burst for the request has finished.
module dram_cmd_scheduler #(
  parameter int BG_WIDTH  = 2,
  parameter int BA_WIDTH  = 2,
  parameter int ROW_WIDTH = 15,
  parameter int COL_WIDTH = 8,
  parameter int CNT_WIDTH = 8,
  parameter int T_RCD     = 24,
  parameter int T_RP      = 24,
  parameter int T_RAS     = 52,
  parameter int T_CL      = 24,
  parameter int T_CWL     = 20,
  parameter int T_BURST   = 4,
  parameter int T_WR      = 20,
  parameter int T_RTP     = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_opcode,
  input  logic [BG_WIDTH-1:0]  req_bg,
  input  logic [BA_WIDTH-1:0]  req_ba,
  input  logic [ROW_WIDTH-1:0] req_row,
  input  logic [COL_WIDTH-1:0] req_col,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_type,
  output logic [BG_WIDTH-1:0]  cmd_bg,
  output logic [BA_WIDTH-1:0]  cmd_ba,
  output logic [ROW_WIDTH-1:0] cmd_addr,
  output logic                 req_done
);

  localparam int BANK_WIDTH = BG_WIDTH + BA_WIDTH;
  localparam int NUM_BANKS  = 1 << BANK_WIDTH;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  // Timing parameters that cannot be represented are rejected at elaboration.
  if (T_RCD < 1 || T_RP < 1 || T_RAS < 1 || T_CL < 1 || T_CWL < 1 ||
      T_BURST < 1 || T_WR < 1 || T_RTP < 1) begin : g_bad_timing
    $fatal(1, "dram_cmd_scheduler: every T_* parameter must be at least 1");
  end
  if (T_CL + T_BURST > CNT_MAX || T_CWL + T_BURST + T_WR > CNT_MAX) begin : g_bad_cnt
    $fatal(1, "dram_cmd_scheduler: CNT_WIDTH too small for the data/recovery windows");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCHED = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_PRE = 3'd2;
  localparam logic [2:0] CMD_RD  = 3'd3;
  localparam logic [2:0] CMD_WR  = 3'd4;

  // Counter reload values: a counter loaded with T-1 at edge E reads 0 at edge E+T.
  localparam logic [CNT_WIDTH-1:0] RCD_LOAD     = CNT_WIDTH'(T_RCD - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LOAD      = CNT_WIDTH'(T_RP - 1);
  localparam logic [CNT_WIDTH-1:0] RAS_LOAD     = CNT_WIDTH'(T_RAS - 1);
  localparam logic [CNT_WIDTH-1:0] RTP_LOAD     = CNT_WIDTH'(T_RTP - 1);
  localparam logic [CNT_WIDTH-1:0] WREC_LOAD    = CNT_WIDTH'(T_CWL + T_BURST + T_WR - 1);
  localparam logic [CNT_WIDTH-1:0] RD_DATA_LOAD = CNT_WIDTH'(T_CL + T_BURST - 1);
  localparam logic [CNT_WIDTH-1:0] WR_DATA_LOAD = CNT_WIDTH'(T_CWL + T_BURST - 1);

  // Saturating decrement shared by all timing counters.
  function automatic logic [CNT_WIDTH-1:0] sat_dec(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? v : v - CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_max(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [1:0]            state;
  logic                  lat_write;
  logic [BANK_WIDTH-1:0] lat_bank;
  logic [ROW_WIDTH-1:0]  lat_row;
  logic [COL_WIDTH-1:0]  lat_col;
  logic [CNT_WIDTH-1:0]  data_cnt;

  logic                  bank_open [NUM_BANKS];
  logic [ROW_WIDTH-1:0]  open_row  [NUM_BANKS];
  logic [CNT_WIDTH-1:0]  act_cnt   [NUM_BANKS];
  logic [CNT_WIDTH-1:0]  col_cnt   [NUM_BANKS];
  logic [CNT_WIDTH-1:0]  pre_cnt   [NUM_BANKS];

  logic do_act;
  logic do_pre;
  logic do_col;

  assign req_ready = (state == ST_IDLE);

  // Decide which single command, if any, the latched request needs this edge.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    do_act = 1'b0;
    do_pre = 1'b0;
    do_col = 1'b0;
    if (state == ST_SCHED) begin
      if (bank_open[lat_bank]) begin
        if (open_row[lat_bank] == lat_row) begin
          do_col = (col_cnt[lat_bank] == '0);
        end else begin
          do_pre = (pre_cnt[lat_bank] == '0);
        end
      end else begin
        do_act = (act_cnt[lat_bank] == '0);
      end
    end
  end

  // Per-bank open state and timing windows; all counters run every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bank table is a small register file, not a RAM, so it is
      // reset: a DIMM reset closes every bank and clears every window.
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_open[b] <= 1'b0;
        open_row[b]  <= '0;
        act_cnt[b]   <= '0;
        col_cnt[b]   <= '0;
        pre_cnt[b]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments; a later assignment below overrides
      // the plain decrement for the bank that a command hits.
      for (int b = 0; b < NUM_BANKS; b++) begin
        act_cnt[b] <= sat_dec(act_cnt[b]);
        col_cnt[b] <= sat_dec(col_cnt[b]);
        pre_cnt[b] <= sat_dec(pre_cnt[b]);
      end
      if (do_act) begin
        col_cnt[lat_bank]   <= RCD_LOAD;
        pre_cnt[lat_bank]   <= RAS_LOAD;
        bank_open[lat_bank] <= 1'b1;
        open_row[lat_bank]  <= lat_row;
      end
      if (do_pre) begin
        act_cnt[lat_bank]   <= RP_LOAD;
        bank_open[lat_bank] <= 1'b0;
      end
      if (do_col) begin
        // Extend, never shorten, the precharge window already running.
        pre_cnt[lat_bank] <= cnt_max(sat_dec(pre_cnt[lat_bank]),
                                     lat_write ? WREC_LOAD : RTP_LOAD);
      end
    end
  end

  // Request FSM plus the registered command and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_write <= 1'b0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      data_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bg    <= '0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      req_done  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bg    <= '0;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      req_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_write <= (req_opcode == 2'd1);
            lat_bank  <= {req_bg, req_ba};
            lat_row   <= req_row;
            lat_col   <= req_col;
            state     <= ST_SCHED;
          end
        end
        ST_SCHED: begin
          if (do_act || do_pre || do_col) begin
            cmd_valid <= 1'b1;
            cmd_bg    <= lat_bank[BANK_WIDTH-1:BA_WIDTH];
            cmd_ba    <= lat_bank[BA_WIDTH-1:0];
          end
          if (do_act) begin
            cmd_type <= CMD_ACT;
            cmd_addr <= lat_row;
          end
          if (do_pre) begin
            cmd_type <= CMD_PRE;
          end
          if (do_col) begin
            cmd_type <= lat_write ? CMD_WR : CMD_RD;
            cmd_addr <= ROW_WIDTH'(lat_col);
            data_cnt <= lat_write ? WR_DATA_LOAD : RD_DATA_LOAD;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_cnt == '0) begin
            req_done <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            data_cnt <= data_cnt - CNT_WIDTH'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Testbench for dram_cmd_scheduler. It runs directed scenarios followed by
// randomized requests. A timestamp-based bank model predicts the edge of every
// command and of req_done.
module tb_dram_cmd_scheduler;

  localparam int BG_WIDTH  = 2;
  localparam int BA_WIDTH  = 2;
  localparam int ROW_WIDTH = 15;
  localparam int COL_WIDTH = 8;
  localparam int CNT_WIDTH = 8;
  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24;
  localparam int T_CWL = 20, T_BURST = 4, T_WR = 20, T_RTP = 12;
  localparam int NEVER = -10000;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_PRE = 3'd2, C_RD = 3'd3, C_WR = 3'd4;

  typedef struct {
    int         e;
    logic [2:0] t;
    logic [1:0] bg;
    logic [1:0] ba;
    logic [14:0] addr;
  } cmd_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [1:0]           req_opcode = '0;
  logic [BG_WIDTH-1:0]  req_bg = '0;
  logic [BA_WIDTH-1:0]  req_ba = '0;
  logic [ROW_WIDTH-1:0] req_row = '0;
  logic [COL_WIDTH-1:0] req_col = '0;
  logic                 cmd_valid;
  logic [2:0]           cmd_type;
  logic [BG_WIDTH-1:0]  cmd_bg;
  logic [BA_WIDTH-1:0]  cmd_ba;
  logic [ROW_WIDTH-1:0] cmd_addr;
  logic                 req_done;

  always #5 clk = ~clk;

  dram_cmd_scheduler #(
    .BG_WIDTH(BG_WIDTH), .BA_WIDTH(BA_WIDTH), .ROW_WIDTH(ROW_WIDTH),
    .COL_WIDTH(COL_WIDTH), .CNT_WIDTH(CNT_WIDTH),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CL(T_CL),
    .T_CWL(T_CWL), .T_BURST(T_BURST), .T_WR(T_WR), .T_RTP(T_RTP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_addr(cmd_addr), .req_done(req_done)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_no = 0;
  int   done_cnt = 0;
  int   done_edge = 0;
  cmd_t obs_q[$];
  cmd_t exp_q[$];

  // Bank model: open row plus the edge of the most recent ACT/PRE/RD/WR.
  bit m_open[16];
  int m_row[16], m_act[16], m_pre[16], m_rd[16], m_wr[16];

  // Results of the most recent request, used by the directed checks.
  int last_acc, obs_act, obs_pre, obs_col, obs_n;
  logic [2:0] obs_first_type;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 16; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = 0;
      m_act[b]  = NEVER;
      m_pre[b]  = NEVER;
      m_rd[b]   = NEVER;
      m_wr[b]   = NEVER;
    end
  endtask

  always @(posedge clk) edge_no <= edge_no + 1;

  // Output monitor: collect commands and completions in the middle of each cycle.
  always @(negedge clk) begin
    cmd_t c;
    if (rst_n) begin
      if (cmd_valid) begin
        c.e = edge_no; c.t = cmd_type; c.bg = cmd_bg; c.ba = cmd_ba; c.addr = cmd_addr;
        obs_q.push_back(c);
      end else begin
        check("nop_when_idle", 32'(cmd_type), 32'(C_NOP));
      end
      if (req_done) begin
        done_edge = edge_no;
        done_cnt++;
        check("ready_with_done", 32'(req_ready), 32'd1);
      end
    end
  end

  // Issue one request, wait for its completion and compare against the model.
  task automatic run_req(input logic [1:0] op, input int b, input int row,
                         input int col, input bit junk);
    bit   ok;
    bit   wr;
    int   base, t, pre_e, act_e, col_e, done_e, n;
    cmd_t c;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    check("ready_before_req", 32'(ok), 32'd1);
    obs_q.delete();
    base       = done_cnt;
    req_valid  = 1'b1;
    req_opcode = op;
    req_bg     = 2'(b >> 2);
    req_ba     = 2'(b);
    req_row    = 15'(row);
    req_col    = 8'(col);
    last_acc   = edge_no + 1;
    @(negedge clk);
    if (junk) begin
      // A stray request while busy must not be latched.
      req_opcode = 2'($urandom);
      req_bg     = 2'($urandom);
      req_ba     = 2'($urandom);
      req_row    = 15'($urandom);
      req_col    = 8'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (done_cnt != base);
    end
    check("done_seen", 32'(ok), 32'd1);

    // Model prediction from the timing rules.
    exp_q.delete();
    wr = (op == 2'd1);
    t  = last_acc + 1;
    if (m_open[b] && m_row[b] == row) begin
      col_e = imax(t, m_act[b] + T_RCD);
    end else begin
      if (m_open[b]) begin
        pre_e = imax(imax(t, m_act[b] + T_RAS),
                     imax(m_rd[b] + T_RTP, m_wr[b] + T_CWL + T_BURST + T_WR));
        c.e = pre_e; c.t = C_PRE; c.bg = 2'(b >> 2); c.ba = 2'(b); c.addr = '0;
        exp_q.push_back(c);
        m_pre[b] = pre_e;
        t = pre_e + 1;
      end
      act_e = imax(t, m_pre[b] + T_RP);
      c.e = act_e; c.t = C_ACT; c.bg = 2'(b >> 2); c.ba = 2'(b); c.addr = 15'(row);
      exp_q.push_back(c);
      m_act[b]  = act_e;
      m_open[b] = 1'b1;
      m_row[b]  = row;
      col_e = act_e + T_RCD;
    end
    c.e = col_e; c.t = wr ? C_WR : C_RD; c.bg = 2'(b >> 2); c.ba = 2'(b); c.addr = 15'(col);
    exp_q.push_back(c);
    if (wr) m_wr[b] = col_e; else m_rd[b] = col_e;
    done_e = col_e + (wr ? T_CWL : T_CL) + T_BURST;

    check("done_edge", 32'(done_edge), 32'(done_e));
    check("cmd_count", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("cmd%0d_edge", i), 32'(obs_q[i].e), 32'(exp_q[i].e));
      check($sformatf("cmd%0d_type", i), 32'(obs_q[i].t), 32'(exp_q[i].t));
      check($sformatf("cmd%0d_bg", i), 32'(obs_q[i].bg), 32'(exp_q[i].bg));
      check($sformatf("cmd%0d_ba", i), 32'(obs_q[i].ba), 32'(exp_q[i].ba));
      check($sformatf("cmd%0d_addr", i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
    end

    obs_act = -1; obs_pre = -1; obs_col = -1;
    obs_n = obs_q.size();
    obs_first_type = (obs_n > 0) ? obs_q[0].t : C_NOP;
    foreach (obs_q[i]) begin
      if (obs_q[i].t == C_ACT) obs_act = obs_q[i].e;
      else if (obs_q[i].t == C_PRE) obs_pre = obs_q[i].e;
      else if (obs_q[i].t == C_RD || obs_q[i].t == C_WR) obs_col = obs_q[i].e;
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act1, wr1, base, b, row;
    bit ok;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_type", 32'(cmd_type), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_req_done", 32'(req_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Closed-bank read: ACT in cycle 1, RD in cycle 25, done in cycle 53.
    run_req(2'd0, 0, 16'h10, 8'h05, 1'b0);
    check("rd1_act_cycle", 32'(obs_act - last_acc), 32'd1);
    check("rd1_rd_cycle", 32'(obs_col - last_acc), 32'(1 + T_RCD));
    check("rd1_done_cycle", 32'(done_edge - last_acc), 32'(1 + T_RCD + T_CL + T_BURST));
    act1 = obs_act;

    // Row-hit write: WR right after accept, done T_CWL+T_BURST later.
    run_req(2'd1, 0, 16'h10, 8'h33, 1'b0);
    check("wr_hit_ncmd", 32'(obs_n), 32'd1);
    check("wr_hit_cycle", 32'(obs_col - last_acc), 32'd1);
    check("wr_hit_done", 32'(done_edge - obs_col), 32'(T_CWL + T_BURST));
    wr1 = obs_col;

    // Row miss straight after the write.
    run_req(2'd2, 0, 16'h20, 8'h07, 1'b0);
    check("miss_pre_after_wr", 32'(obs_pre - wr1), 32'(T_CWL + T_BURST + T_WR));
    check("miss_pre_after_act", 32'(obs_pre - act1 >= T_RAS), 32'd1);
    check("miss_act_after_pre", 32'(obs_act - obs_pre), 32'(T_RP));
    check("miss_rd_after_act", 32'(obs_col - obs_act), 32'(T_RCD));

    // Bank independence.
    run_req(2'd3, 7, 16'h7, 8'h01, 1'b0);
    run_req(2'd0, 0, 16'h20, 8'h09, 1'b0);
    check("indep_ncmd", 32'(obs_n), 32'd1);
    check("indep_type", 32'(obs_first_type), 32'(C_RD));

    // Reset during DATA of a read.
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
    end
    check("abort_ready", 32'(ok), 32'd1);
    base = done_cnt;
    req_valid = 1'b1; req_opcode = 2'd0; req_bg = 2'd0; req_ba = 2'd0;
    req_row = 15'h20; req_col = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = cmd_valid;
      if (!ok) @(negedge clk);
    end
    check("abort_rd_seen", 32'(ok), 32'd1);
    check("abort_rd_type", 32'(cmd_type), 32'(C_RD));
    rst_n = 1'b0;
    #1;
    check("abort_cmd_valid", 32'(cmd_valid), 32'd0);
    check("abort_cmd_type", 32'(cmd_type), 32'd0);
    check("abort_cmd_addr", 32'(cmd_addr), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(base));
    model_reset();
    run_req(2'd0, 0, 16'h20, 8'h12, 1'b0);
    check("post_rst_first_act", 32'(obs_first_type), 32'(C_ACT));
    check("post_rst_act_cycle", 32'(obs_act - last_acc), 32'd1);

    // Randomized traffic over four banks and three rows.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      b   = 5 * int'($urandom_range(0, 3));
      row = 3 + 100 * int'($urandom_range(0, 2));
      run_req(2'($urandom_range(0, 3)), b, row, int'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
